// File: rtl/core_inst_seq_if.sv
// core_inst_seq_if: host/core-facing signals of the instruction sequencer.
interface core_inst_seq_if;
    logic        start, mode_sel, ofifo_valid;
    logic [10:0] acc_addr;
    logic [7:0]  acc_idx;
    logic [34:0] inst;
    logic        sfp_clr, out_strobe, busy, done;
    modport master (input start, mode_sel, ofifo_valid, acc_addr,
                    output acc_idx, inst, sfp_clr, out_strobe, busy, done);
    modport slave (output start, mode_sel, ofifo_valid, acc_addr,
                   input acc_idx, inst, sfp_clr, out_strobe, busy, done);
endinterface

// File: rtl/core_inst_seq.sv
// core_inst_seq: drives the 35-bit core instruction word through a full 3x3
// convolution pass (9 kij iterations) followed by per-pixel accumulation.
module core_inst_seq #(
    parameter int          row      = 8,
    parameter int          col      = 8,
    parameter int          len_nij  = 36,
    parameter int          len_kij  = 9,
    parameter int          len_onij = 16,
    parameter logic [10:0] w_base   = 11'h400,
    parameter int          drain    = row + col
) (
    input logic             clk,
    input logic             reset,
    core_inst_seq_if.master bus
);
    typedef enum logic [3:0] {IDLE, W_L0, W_LOAD, GAP1, A_L0, EXEC, GAP2, OFIFO, CLR, ACC, OUT, DONE} state_t;
    state_t      state, state_n;
    logic [7:0]  i, i_n;
    logic [3:0]  kij, kij_n;
    logic [4:0]  onij, onij_n;
    logic        mode, mode_n, xfer;
    logic        acc, cen_p, wen_p, cen_x, wen_x, ofifo_rd, l0_rd, l0_wr, exe, load;
    logic [10:0] a_p, a_x;
    // In OFIFO, i counts transfers already issued; elsewhere it is the index of the word on inst.
    always_comb begin
        state_n = state;
        i_n     = i + 8'd1;
        kij_n   = kij;
        onij_n  = onij;
        mode_n  = mode;
        xfer    = 1'b0;
        case (state)
            IDLE: begin
                i_n = '0;
                if (bus.start) begin
                    state_n = W_L0;
                    kij_n   = '0;
                    mode_n  = bus.mode_sel;
                end
            end
            W_L0:   if (i == 8'(col - 1)) begin state_n = W_LOAD; i_n = '0; end
            W_LOAD: if (i == 8'(col - 1)) begin state_n = GAP1; i_n = '0; end
            GAP1:   if (i == 8'(drain - 1)) begin state_n = A_L0; i_n = '0; end
            A_L0:   if (i == 8'(len_nij - 1)) begin state_n = EXEC; i_n = '0; end
            EXEC:   if (i == 8'(len_nij - 1)) begin state_n = GAP2; i_n = '0; end
            GAP2: begin
                if (i == 8'(drain - 1)) begin
                    state_n = OFIFO;
                    xfer    = bus.ofifo_valid;
                    i_n     = {7'd0, bus.ofifo_valid};
                end
            end
            OFIFO: begin
                if (i == 8'(len_nij)) begin
                    i_n = '0;
                    if (kij == 4'(len_kij - 1)) begin
                        state_n = CLR;
                        onij_n  = '0;
                    end else begin
                        state_n = W_L0;
                        kij_n   = kij + 4'd1;
                    end
                end else begin
                    xfer = bus.ofifo_valid;
                    i_n  = bus.ofifo_valid ? i + 8'd1 : i;
                end
            end
            CLR: begin state_n = ACC; i_n = '0; end
            ACC: if (i == 8'(len_kij)) begin state_n = OUT; i_n = '0; end
            OUT: begin
                i_n = '0;
                if (onij == 5'(len_onij - 1)) state_n = DONE;
                else begin
                    state_n = CLR;
                    onij_n  = onij + 5'd1;
                end
            end
            DONE:    begin state_n = IDLE; i_n = '0; end
            default: begin state_n = IDLE; i_n = '0; end
        endcase
    end
    always_comb begin
        acc = 1'b0; cen_p = 1'b1; wen_p = 1'b1; a_p = '0;
        cen_x = 1'b1; wen_x = 1'b1; a_x = '0;
        ofifo_rd = 1'b0; l0_rd = 1'b0; l0_wr = 1'b0; exe = 1'b0; load = 1'b0;
        case (state_n)
            W_L0: begin
                cen_x = 1'b0;
                l0_wr = 1'b1;
                a_x   = w_base + 11'(kij_n) * 11'(col) + 11'(i_n);
            end
            W_LOAD: begin l0_rd = 1'b1; load = 1'b1; end
            A_L0: begin
                cen_x = 1'b0;
                l0_wr = 1'b1;
                a_x   = 11'(i_n);
            end
            EXEC: begin l0_rd = 1'b1; exe = 1'b1; end
            OFIFO: begin
                if (xfer) begin
                    ofifo_rd = 1'b1;
                    cen_p    = 1'b0;
                    wen_p    = 1'b0;
                    a_p      = 11'(kij_n) * 11'(len_nij) + (state == OFIFO ? 11'(i) : 11'd0);
                end
            end
            // acc_idx runs one word ahead so acc_addr is settled when the read word is registered
            ACC: begin
                cen_p = i_n == 8'(len_kij);
                a_p   = i_n == 8'(len_kij) ? 11'd0 : bus.acc_addr;
                acc   = i_n != 8'd0;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            i              <= '0;
            kij            <= '0;
            onij           <= '0;
            mode           <= 1'b0;
            bus.inst       <= 35'h1_800C_0000;
            bus.acc_idx    <= '0;
            bus.sfp_clr    <= 1'b0;
            bus.out_strobe <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state          <= state_n;
            i              <= i_n;
            kij            <= kij_n;
            onij           <= onij_n;
            mode           <= mode_n;
            bus.inst       <= {mode_n, acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
                               ofifo_rd, 2'b00, l0_rd, l0_wr, exe, load};
            bus.acc_idx    <= 8'(onij_n * len_kij) + (state_n == ACC ? i_n + 8'd1 : 8'd0);
            bus.sfp_clr    <= state_n == CLR;
            bus.out_strobe <= state_n == OUT;
            bus.busy       <= state_n != IDLE && state_n != DONE;
            bus.done       <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: scoreboard bench for the instruction sequencer.
module tb_core_inst_seq;
    localparam logic [34:0] IDLE_W = 35'h1_800C_0000;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int passed = 0;
    int total = 0;
    core_inst_seq_if bus();
    core_inst_seq dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    assign bus.acc_addr = 11'(bus.acc_idx) * 11'd3;
    wire        acc_b    = bus.inst[33];
    wire        cen_p    = bus.inst[32];
    wire        wen_p    = bus.inst[31];
    wire [10:0] a_p      = bus.inst[30:20];
    wire [10:0] a_x      = bus.inst[17:7];
    wire        ofifo_rd = bus.inst[6];
    wire        l0_wr    = bus.inst[2];
    wire        exe      = bus.inst[1];

    task automatic start_pass(input logic m);
        bus.mode_sel = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        int c = 0;
        while (!bus.done && c < 5000) begin
            @(negedge clk);
            c++;
        end
        seen = bus.done;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.mode_sel = 1'b0;
        bus.ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.inst !== IDLE_W) $display("FAIL reset_inst: got %h want %h", bus.inst, IDLE_W);
        else passed++;
        total++;
        if ({bus.busy, bus.done, bus.sfp_clr, bus.out_strobe} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.sfp_clr, bus.out_strobe});
        else passed++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_weight_addr;
        logic [10:0] q[$];
        int runs[$];
        int run = 0, cyc = 0, er;
        logic [10:0] ea;
        logic seen;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 8; n++) q.push_back(11'h400 + 11'(k * 8 + n));
            for (int n = 0; n < 36; n++) q.push_back(11'(n));
            runs.push_back(8);
            runs.push_back(36);
        end
        bus.ofifo_valid = 1'b1;
        start_pass(1'b1);
        total++;
        if ({bus.inst[34], l0_wr, a_x} !== {1'b1, 1'b1, 11'h400})
            $display("FAIL weight_first: got mode=%b l0_wr=%b A_xmem=%h want 1 1 400", bus.inst[34], l0_wr, a_x);
        else passed++;
        while (runs.size() > 0 && cyc < 3000) begin
            if (l0_wr) begin
                run++;
                ea = q.size() > 0 ? q.pop_front() : 11'h7ff;
                total++;
                if (a_x !== ea) $display("FAIL weight_addr: got %h want %h", a_x, ea);
                else passed++;
            end else if (run > 0) begin
                er = runs.pop_front();
                total++;
                if (run != er) $display("FAIL l0_run_len: got %0d want %0d", run, er);
                else passed++;
                run = 0;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (runs.size() != 0) $display("FAIL weight_timeout: got %0d runs left want 0", runs.size());
        else passed++;
        wait_done(seen);
        total++;
        if (!seen) $display("FAIL weight_done: got no done want done");
        else passed++;
    endtask

    task automatic test_ofifo_stall;
        logic [10:0] q[$];
        logic [10:0] ea;
        int n = 0, stall = 0, low = 0, cyc = 0;
        for (int a = 0; a < 324; a++) q.push_back(11'(a));
        bus.ofifo_valid = 1'b1;
        start_pass(1'b0);
        while (!bus.done && cyc < 5000) begin
            if (low > 0) begin
                low--;
                if (low == 0) bus.ofifo_valid = 1'b1;
            end
            if (ofifo_rd) begin
                ea = q.size() > 0 ? q.pop_front() : 11'h7ff;
                total++;
                if (a_p !== ea || cen_p !== 1'b0 || wen_p !== 1'b0)
                    $display("FAIL pmem_write: got A=%0d CEN=%b WEN=%b want A=%0d CEN=0 WEN=0", a_p, cen_p, wen_p, ea);
                else passed++;
                n++;
                if (n == 46) begin
                    bus.ofifo_valid = 1'b0;
                    low = 5;
                end
            end else if (n == 46) begin
                stall++;
                total++;
                if (cen_p !== 1'b1) $display("FAIL stall_cen: got %b want 1", cen_p);
                else passed++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.ofifo_valid = 1'b1;
        total++;
        if (stall != 5) $display("FAIL stall_len: got %0d want 5", stall);
        else passed++;
        total++;
        if (n != 324 || q.size() != 0) $display("FAIL xfer_count: got %0d left %0d want 324 left 0", n, q.size());
        else passed++;
        total++;
        if (!bus.done) $display("FAIL stall_done: got no done want done");
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_accumulation;
        logic [10:0] q[$];
        logic [10:0] ea;
        int k = -1, hi = 0, strobes = 0, clrs = 0, cyc = 0, o = 0;
        for (int p = 0; p < 16; p++)
            for (int j = 0; j < 9; j++) q.push_back(11'((p * 9 + j) * 3));
        bus.ofifo_valid = 1'b1;
        start_pass(1'b0);
        while (!bus.done && cyc < 5000) begin
            if (!cen_p && wen_p) begin
                ea = q.size() > 0 ? q.pop_front() : 11'h7ff;
                total++;
                if (a_p !== ea) $display("FAIL acc_addr: got %0d want %0d", a_p, ea);
                else passed++;
            end
            if (bus.sfp_clr) begin
                clrs++;
                k = 0;
                hi = 0;
            end else if (k >= 0) begin
                k++;
                hi += int'(acc_b);
                if (k == 11) begin
                    total++;
                    if (bus.out_strobe !== 1'b1 || hi != 9 || acc_b !== 1'b0)
                        $display("FAIL acc_window onij=%0d: got strobe=%b acc_cycles=%0d want strobe=1 acc_cycles=9", o, bus.out_strobe, hi);
                    else passed++;
                    k = -1;
                    o++;
                end
            end
            strobes += int'(bus.out_strobe);
            @(negedge clk);
            cyc++;
        end
        total++;
        if (strobes != 16 || clrs != 16) $display("FAIL acc_pulses: got strobes=%0d clrs=%0d want 16 16", strobes, clrs);
        else passed++;
        total++;
        if (q.size() != 0) $display("FAIL acc_reads_left: got %0d want 0", q.size());
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_end_to_end;
        int b = 0, d = 0;
        bus.ofifo_valid = 1'b1;
        start_pass(1'b0);
        for (int cyc = 0; cyc < 1700; cyc++) begin
            b += int'(bus.busy);
            d += int'(bus.done);
            bus.start = cyc == 100 || cyc == 900;
            @(negedge clk);
        end
        bus.start = 1'b0;
        total++;
        if (b != 1596) $display("FAIL busy_cycles: got %0d want 1596", b);
        else passed++;
        total++;
        if (d != 1) $display("FAIL done_pulses: got %0d want 1", d);
        else passed++;
        total++;
        if (bus.inst !== IDLE_W || bus.busy !== 1'b0) $display("FAIL end_idle: got %h busy=%b want %h busy=0", bus.inst, bus.busy, IDLE_W);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int ex = 0, d = 0, b = 0, cyc = 0;
        logic prev = 1'b0;
        bus.ofifo_valid = 1'b1;
        start_pass(1'b1);
        while (cyc < 2000) begin
            if (exe && !prev) ex++;
            prev = exe;
            if (ex == 5) break;
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (exe !== 1'b1) $display("FAIL mid_exec: got execute=%b want 1", exe);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.inst !== IDLE_W || bus.busy !== 1'b0) $display("FAIL mid_reset: got %h busy=%b want %h busy=0", bus.inst, bus.busy, IDLE_W);
        else passed++;
        reset = 1'b1;
        repeat (50) begin
            d += int'(bus.done);
            @(negedge clk);
        end
        total++;
        if (d != 0 || bus.busy !== 1'b0) $display("FAIL abort_quiet: got done=%0d busy=%b want 0 0", d, bus.busy);
        else passed++;
        start_pass(1'b0);
        total++;
        if ({l0_wr, a_x} !== {1'b1, 11'h400}) $display("FAIL restart_first: got l0_wr=%b A_xmem=%h want 1 400", l0_wr, a_x);
        else passed++;
        d = 0;
        for (int c = 0; c < 1700; c++) begin
            b += int'(bus.busy);
            d += int'(bus.done);
            @(negedge clk);
        end
        total++;
        if (b != 1596 || d != 1) $display("FAIL restart_pass: got busy=%0d done=%0d want 1596 1", b, d);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_weight_addr;
        test_ofifo_stall;
        test_accumulation;
        test_end_to_end;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
